// File: rtl/sseg_scroll_feeder.sv
// Nibble queue feeding an 8-digit scrolling display register, with a fast anode scan
// that hands one nibble, its blank flag and an active-low anode vector to the hex decoder.
module sseg_scroll_feeder #(
    parameter int SCAN_DIV   = 100000,
    parameter int SCROLL_DIV = 50000000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [3:0]                    WR_DATA,
    input  logic                          WR_VALID,
    output logic                          WR_READY,
    input  logic                          FLUSH,
    output logic [3:0]                    DIGIT,
    output logic                          DIGIT_BLANK,
    output logic [7:0]                    SSEG_AN,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          SCROLL_PULSE
);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int SCR_W  = $clog2(SCROLL_DIV);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [SCAN_W-1:0] SCAN_TC  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCR_W-1:0]  SCR_TC   = SCR_W'(SCROLL_DIV - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [SCAN_W-1:0] scan_cnt;
    logic [SCR_W-1:0]  scr_cnt;
    logic [2:0]        idx;
    logic [3:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [7:0]        slot_v;
    logic [3:0]        slot_n [8];
    logic              scan_tc;
    logic              scr_tc;
    logic              full;
    logic              has_data;
    logic              push;
    logic              pop;

    assign scan_tc      = (scan_cnt == SCAN_TC);
    assign scr_tc       = (scr_cnt == SCR_TC);
    assign full         = (count == FULL_CNT);
    assign has_data     = (count != '0);
    assign WR_READY     = !full && !RST;
    // A write offered while FLUSH is high is dropped even though READY is high.
    assign push         = WR_VALID && WR_READY && !FLUSH;
    assign pop          = scr_tc && !FLUSH && has_data;
    assign SCROLL_PULSE = scr_tc && !FLUSH && !RST;
    assign FIFO_COUNT   = count;

    always_ff @(posedge CLK) begin
        if (push)
            fifo_mem[wr_ptr] <= WR_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_cnt    <= '0;
            idx         <= '0;
            scr_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            slot_v      <= '0;
            for (int k = 0; k < 8; k++)
                slot_n[k] <= '0;
            SSEG_AN     <= 8'hFE;
            DIGIT       <= '0;
            DIGIT_BLANK <= 1'b1;
        end else begin
            scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
            if (scan_tc)
                idx <= idx + 3'd1;
            // Refreshed every cycle so a scroll shows on the selected digit promptly.
            SSEG_AN     <= ~(8'd1 << idx);
            DIGIT       <= slot_n[idx];
            DIGIT_BLANK <= ~slot_v[idx];

            if (FLUSH) begin
                scr_cnt <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                slot_v  <= '0;
                for (int k = 0; k < 8; k++)
                    slot_n[k] <= '0;
            end else begin
                scr_cnt <= scr_tc ? '0 : scr_cnt + 1'b1;
                if (scr_tc) begin
                    slot_v <= {slot_v[6:0], has_data};
                    for (int k = 7; k > 0; k--)
                        slot_n[k] <= slot_n[k-1];
                    slot_n[0] <= has_data ? fifo_mem[rd_ptr] : 4'd0;
                end
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end
endmodule

// File: tb/tb_sseg_scroll_feeder.sv
// Scoreboard bench for sseg_scroll_feeder: accepted nibbles queue up in a reference
// model; a negedge monitor compares every output against the model each cycle.
module tb_sseg_scroll_feeder;
    localparam int SCAN_DIV   = 4;
    localparam int SCROLL_DIV = 40;
    localparam int FIFO_DEPTH = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] WR_DATA;
    logic       WR_VALID;
    logic       WR_READY;
    logic       FLUSH;
    logic [3:0] DIGIT;
    logic       DIGIT_BLANK;
    logic [7:0] SSEG_AN;
    logic [3:0] FIFO_COUNT;
    logic       SCROLL_PULSE;

    sseg_scroll_feeder #(
        .SCAN_DIV  (SCAN_DIV),
        .SCROLL_DIV(SCROLL_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .WR_DATA     (WR_DATA),
        .WR_VALID    (WR_VALID),
        .WR_READY    (WR_READY),
        .FLUSH       (FLUSH),
        .DIGIT       (DIGIT),
        .DIGIT_BLANK (DIGIT_BLANK),
        .SSEG_AN     (SSEG_AN),
        .FIFO_COUNT  (FIFO_COUNT),
        .SCROLL_PULSE(SCROLL_PULSE)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: exp_q is the expected queue contents, disp[0] is the rightmost slot
    // as {valid, nibble}; m_t counts cycles since reset, m_scr cycles in the scroll period.
    logic [3:0] exp_q [$];
    logic [4:0] disp [$];
    int         m_t;
    int         m_scr;
    bit         m_ok = 1'b0;
    logic [7:0] e_an;
    logic [3:0] e_dig;
    logic       e_blank;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic blank_disp();
        disp.delete();
        repeat (8) disp.push_back(5'd0);
    endtask

    always @(posedge CLK) begin : model
        int  sel;
        bit  room;
        if (RST) begin
            m_ok    = 1'b1;
            m_t     = 0;
            m_scr   = 0;
            exp_q.delete();
            blank_disp();
            e_an    = 8'hFE;
            e_dig   = 4'd0;
            e_blank = 1'b1;
        end else begin
            sel     = (m_t / SCAN_DIV) % 8;
            e_an    = ~(8'd1 << sel);
            e_dig   = disp[sel][3:0];
            e_blank = ~disp[sel][4];
            m_t++;
            if (FLUSH) begin
                exp_q.delete();
                blank_disp();
                m_scr = 0;
            end else begin
                room = exp_q.size() < FIFO_DEPTH;
                if (m_scr == SCROLL_DIV - 1) begin
                    void'(disp.pop_back());
                    if (exp_q.size() > 0)
                        disp.push_front({1'b1, exp_q.pop_front()});
                    else
                        disp.push_front(5'd0);
                    m_scr = 0;
                end else begin
                    m_scr++;
                end
                if (WR_VALID && room)
                    exp_q.push_back(WR_DATA);
            end
        end
    end

    always @(negedge CLK) begin
        if (m_ok) begin
            chk("sseg_an", SSEG_AN, e_an);
            chk("digit", {4'd0, DIGIT}, {4'd0, e_dig});
            chk("digit_blank", {7'd0, DIGIT_BLANK}, {7'd0, e_blank});
            chk("fifo_count", {4'd0, FIFO_COUNT}, 8'(exp_q.size()));
            chk("wr_ready", {7'd0, WR_READY}, {7'd0, !RST && (exp_q.size() < FIFO_DEPTH)});
            chk("scroll_pulse", {7'd0, SCROLL_PULSE},
                {7'd0, !RST && !FLUSH && (m_scr == SCROLL_DIV - 1)});
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic push_nib(input logic [3:0] v);
        bit done = 1'b0;
        WR_VALID = 1'b1;
        WR_DATA  = v;
        for (int i = 0; i < 200 && !done; i++) begin
            if (WR_READY && !FLUSH) done = 1'b1;
            cyc();
        end
        WR_VALID = 1'b0;
        if (!done) begin
            miscompares++;
            $display("FAIL push_timeout: nibble %h not accepted", v);
        end
    endtask

    task automatic wait_scr(input int val);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_scr == val) hit = 1'b1;
            else cyc();
        end
        if (!hit) begin
            miscompares++;
            $display("FAIL scroll_phase_timeout: phase %0d not reached", val);
        end
    endtask

    initial begin
        int  n;
        bit  hit;
        RST      = 1'b1;
        WR_VALID = 1'b0;
        WR_DATA  = 4'd0;
        FLUSH    = 1'b0;
        repeat (3) cyc();
        RST = 1'b0;
        repeat (40) cyc();

        // Three nibbles scroll in; slot2 should then show 1.
        push_nib(4'h1);
        push_nib(4'h2);
        push_nib(4'h3);
        for (int p = 0; p < 3; p++) begin
            wait_scr(SCROLL_DIV - 1);
            cyc();
        end
        cyc();
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge CLK);
            if (SSEG_AN == 8'hFB) hit = 1'b1;
        end
        chk_int("t3_an_fb_seen", int'(hit), 1);
        chk("t3_digit", {4'd0, DIGIT}, 8'h01);
        chk("t3_blank", {7'd0, DIGIT_BLANK}, 8'h00);
        chk("t3_count", {4'd0, FIFO_COUNT}, 8'h00);

        // Fill the queue at the start of a scroll period, then hold a 9th write.
        cyc();
        wait_scr(0);
        for (int i = 0; i < 8; i++) push_nib(4'(i + 4));
        chk("t4_full_count", {4'd0, FIFO_COUNT}, 8'h08);
        WR_VALID = 1'b1;
        WR_DATA  = 4'h9;
        n = 0;
        while (!WR_READY && n < 100) begin
            n++;
            cyc();
        end
        chk_int("t4_ready_low_cycles", n, SCROLL_DIV - 8);
        cyc();
        WR_VALID = 1'b0;
        chk("t4_refill_count", {4'd0, FIFO_COUNT}, 8'h08);

        // Drain, then push during the pulse with one entry queued and with none.
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            n++;
            cyc();
        end
        push_nib(4'h7);
        wait_scr(SCROLL_DIV - 1);
        WR_VALID = 1'b1;
        WR_DATA  = 4'hA;
        cyc();
        WR_VALID = 1'b0;
        chk("t5_count_one", {4'd0, FIFO_COUNT}, 8'h01);
        wait_scr(SCROLL_DIV - 1);
        cyc();
        wait_scr(SCROLL_DIV - 1);
        WR_VALID = 1'b1;
        WR_DATA  = 4'hB;
        cyc();
        WR_VALID = 1'b0;
        chk("t5_empty_push_count", {4'd0, FIFO_COUNT}, 8'h01);

        // Flush mid-period with five queued.
        for (int i = 0; i < 4; i++) push_nib(4'(i + 1));
        wait_scr(20);
        FLUSH = 1'b1;
        cyc();
        FLUSH = 1'b0;
        chk("t6_count", {4'd0, FIFO_COUNT}, 8'h00);
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 100) begin
            @(negedge CLK);
            n++;
            if (SCROLL_PULSE) hit = 1'b1;
            else if (n >= 2) chk("t6_blank", {7'd0, DIGIT_BLANK}, 8'h01);
        end
        chk_int("t6_pulse_delay", n, SCROLL_DIV);

        // Randomized traffic with occasional flush and one mid-run reset.
        for (int c = 0; c < 2000; c++) begin
            int win;
            win      = (c / 200) % 3;
            WR_VALID = ($urandom_range(0, 9) < (win == 0 ? 2 : (win == 1 ? 5 : 9)));
            WR_DATA  = 4'($urandom);
            FLUSH    = ($urandom_range(0, 149) == 0);
            RST      = (c >= 1000 && c < 1002);
            cyc();
        end
        RST      = 1'b0;
        WR_VALID = 1'b0;
        FLUSH    = 1'b0;
        repeat (5) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
